// File: rtl/golden_nonce_collector.sv
// golden_nonce_collector
// Captures per-lane golden-ticket hits from the quad-lane miner, converts
// each hit to its originating 32-bit nonce, and queues the results in a
// first-word-fall-through FIFO that feeds a valid/ready stream.
// Optional build macro: GN_DROP_COUNT_EN adds an 8-bit saturating drop_count
// output that counts hits lost because their lane was still pending.
module golden_nonce_collector #(
  parameter int          DEPTH_LOG2   = 3,
  parameter logic [31:0] NONCE_OFFSET = 32'd131
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic [3:0]            is_golden,
  input  logic [29:0]           nonce,
  output logic                  gn_valid,
  output logic [31:0]           gn_data,
  input  logic                  gn_ready,
  output logic [DEPTH_LOG2:0]   fifo_level
`ifdef GN_DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  // Capture stage: one held result per lane
  logic [31:0] cap_nonce [4];
  logic [3:0]  pend;
  logic [3:0]  load;

  // Arbiter
  logic [1:0]  grant_idx;
  logic [3:0]  grant_oh;
  logic        grant_any;

  // FIFO
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [DEPTH_LOG2:0]   level_after_pop;
  logic [31:0]           head_nxt;
  logic [31:0]           wdata;
  logic                  push;
  logic                  pop;
  logic                  full;

  // Fixed-priority grant of the lowest pending lane when the FIFO can take it
  always_comb begin
    grant_idx = 2'd0;
    grant_oh  = 4'b0000;
    pop       = gn_valid && gn_ready;
    full      = (fifo_level == LEVEL_MAX);
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    grant_any = (|pend) && (!full || pop);
    casez (pend)
      4'b???1: grant_idx = 2'd0;
      4'b??10: grant_idx = 2'd1;
      4'b?100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
    if (grant_any) grant_oh = 4'b0001 << grant_idx;
  end

  // A hit is taken if its lane is idle or is being drained this same cycle
  always_comb begin
    load = is_golden & (~pend | grant_oh);
  end

  // Capture registers: corrected nonce (wraps modulo 2^32) and pend bit per lane
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) cap_nonce[i] <= 32'd0;
      pend <= 4'b0000;
    end else begin
      // NOTE: state registers use non-blocking assignments so every lane sees
      // the pre-edge pend/grant values, independent of statement order.
      for (int i = 0; i < 4; i++) begin
        if (load[i]) cap_nonce[i] <= {2'(i), nonce} - NONCE_OFFSET;
      end
      pend <= load | (pend & ~grant_oh);
    end
  end

  // FIFO next-state: level, read pointer and the entry that becomes the head
  always_comb begin
    push            = grant_any;
    wdata           = cap_nonce[grant_idx];
    level_after_pop = fifo_level - (DEPTH_LOG2 + 1)'(pop);
    level_nxt       = level_after_pop + (DEPTH_LOG2 + 1)'(push);
    rd_ptr_nxt      = rd_ptr + DEPTH_LOG2'(pop);
    // If nothing older remains after the pop, the pushed word is the new head.
    head_nxt        = (level_after_pop == '0) ? wdata : mem[rd_ptr_nxt];
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and level, which are reset, so stale contents are never presented.
  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // FIFO control and registered head-of-queue output
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      gn_valid   <= 1'b0;
      gn_data    <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      gn_valid   <= (level_nxt != '0);
      if (level_nxt != '0) gn_data <= head_nxt;
    end
  end

`ifdef GN_DROP_COUNT_EN
  logic [3:0] drop;
  logic [2:0] drop_num;
  logic [8:0] drop_sum;

  // Count hits that arrive on a lane still pending and not drained this cycle
  always_comb begin
    drop     = is_golden & pend & ~grant_oh;
    drop_num = 3'd0;
    for (int i = 0; i < 4; i++) drop_num = drop_num + 3'(drop[i]);
    drop_sum = 9'(drop_count) + 9'(drop_num);
  end

  // Saturating drop counter
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) drop_count <= 8'd0;
    else          drop_count <= drop_sum[8] ? 8'd255 : drop_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Testbench for golden_nonce_collector: directed scenarios plus a randomized
// run, checked against a queue-based reference model of the collector.
module tb_golden_nonce_collector;

  localparam int          DL    = 2;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] OFF   = 32'd131;

  logic          hash_clk = 1'b0;
  logic          reset_n;
  logic [3:0]    is_golden;
  logic [29:0]   nonce;
  logic          gn_valid;
  logic [31:0]   gn_data;
  logic          gn_ready;
  logic [DL:0]   fifo_level;
`ifdef GN_DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_pend [4];
  logic [31:0] m_cap  [4];
  logic [31:0] m_q    [$];
  int          m_drops;

  logic [31:0] exp_vals [8];

  always #5 hash_clk = ~hash_clk;

  golden_nonce_collector #(
    .DEPTH_LOG2   (DL),
    .NONCE_OFFSET (OFF)
  ) dut (
    .hash_clk   (hash_clk),
    .reset_n    (reset_n),
    .is_golden  (is_golden),
    .nonce      (nonce),
    .gn_valid   (gn_valid),
    .gn_data    (gn_data),
    .gn_ready   (gn_ready),
    .fifo_level (fifo_level)
`ifdef GN_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] corrected(input int lane, input logic [29:0] n);
    return ((32'(lane) << 30) + 32'(n)) - OFF;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_cap[i]  = 32'd0;
    end
    m_q.delete();
    m_drops = 0;
  endfunction

  // One clock edge of the collector, described in terms of queues and lanes
  function automatic void model_clock(input logic [3:0] hits, input logic [29:0] n, input bit rdy);
    int  g    = -1;
    bit  pop  = (m_q.size() > 0) && rdy;
    bit  room = (m_q.size() < DEPTH) || pop;
    if (room) begin
      for (int i = 0; i < 4; i++) if (m_pend[i] && g < 0) g = i;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(m_cap[g]);
    for (int i = 0; i < 4; i++) begin
      if (hits[i]) begin
        if (!m_pend[i] || i == g) begin
          m_cap[i]  = corrected(i, n);
          m_pend[i] = 1'b1;
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end else if (i == g) begin
        m_pend[i] = 1'b0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(gn_valid), 32'(m_q.size() > 0));
    check({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
    if (m_q.size() > 0) check({tag, ".data"}, gn_data, m_q[0]);
`ifdef GN_DROP_COUNT_EN
    check({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare outputs
  task automatic step(input logic [3:0] g, input logic [29:0] n, input bit r, input string tag);
    is_golden = g;
    nonce     = n;
    gn_ready  = r;
    @(posedge hash_clk);
    model_clock(g, n, r);
    #1;
    compare_all(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    is_golden = 4'b0000;
    nonce     = 30'd0;
    gn_ready  = 1'b0;
    model_reset();
    #3;
    check("reset.valid", 32'(gn_valid), 32'd0);
    check("reset.level", 32'(fifo_level), 32'd0);
    check("reset.data", gn_data, 32'd0);
`ifdef GN_DROP_COUNT_EN
    check("reset.drops", 32'(drop_count), 32'd0);
`endif
    #20;
    @(negedge hash_clk);
    reset_n = 1'b1;
    step(4'b0000, 30'd0, 1'b0, "idle");

    // Single hit on lane 1: visible two edges later, no bypass
    step(4'b0010, 30'h0000_1000, 1'b0, "single");
    check("single.no_bypass", 32'(gn_valid), 32'd0);
    step(4'b0000, 30'd0, 1'b0, "single");
    check("single.valid", 32'(gn_valid), 32'd1);
    check("single.data", gn_data, 32'h4000_0F7D);
    step(4'b0000, 30'd0, 1'b1, "single_pop");
    check("single.empty", 32'(gn_valid), 32'd0);
    check("single.level0", 32'(fifo_level), 32'd0);

    // Simultaneous hits on all lanes drain in lane order; lane 0 wraps below zero
    exp_vals[0] = 32'hFFFF_FF8D;
    exp_vals[1] = 32'h3FFF_FF8D;
    exp_vals[2] = 32'h7FFF_FF8D;
    exp_vals[3] = 32'hBFFF_FF8D;
    step(4'b1111, 30'h10, 1'b1, "simul");
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 30'd0, 1'b1, "simul");
      check($sformatf("simul.beat%0d", k), gn_data, exp_vals[k]);
    end
    step(4'b0000, 30'd0, 1'b1, "simul_end");
    check("simul.empty", 32'(gn_valid), 32'd0);

    // Backpressure: six lane-0 pulses, four queued, one held, one dropped
    for (int p = 0; p < 6; p++) begin
      exp_vals[p] = corrected(0, 30'(100 + 7 * p));
      step(4'b0001, 30'(100 + 7 * p), 1'b0, "bp_hit");
      step(4'b0000, 30'd0, 1'b0, "bp_gap");
    end
    check("bp.level_full", 32'(fifo_level), 32'd4);
`ifdef GN_DROP_COUNT_EN
    check("bp.drop_count", 32'(drop_count), 32'd1);
`endif
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp.drain%0d", k), gn_data, exp_vals[k]);
      step(4'b0000, 30'd0, 1'b1, "bp_drain");
    end
    check("bp.drained", 32'(fifo_level), 32'd0);

    // Full FIFO with lane 2 pending and a single pop: push and pop together
    step(4'b1111, 30'h2000, 1'b0, "full_fill");
    for (int k = 0; k < 4; k++) step(4'b0000, 30'd0, 1'b0, "full_fill");
    check("full.level", 32'(fifo_level), 32'd4);
    step(4'b0100, 30'h3000, 1'b0, "full_pend");
    step(4'b0000, 30'd0, 1'b1, "full_pushpop");
    check("full.pushpop_level", 32'(fifo_level), 32'd4);
    step(4'b0000, 30'd0, 1'b0, "full_hold");
    for (int k = 0; k < 4; k++) step(4'b0000, 30'd0, 1'b1, "full_drain");
    check("full.last_is_lane2", 32'(fifo_level), 32'd0);

    // Re-hit on lane 0 in the cycle it is granted: both captured
    step(4'b0001, 30'h55, 1'b0, "rehit");
    step(4'b0001, 30'h56, 1'b0, "rehit");
    step(4'b0000, 30'd0, 1'b0, "rehit");
    step(4'b0000, 30'd0, 1'b0, "rehit");
    check("rehit.level", 32'(fifo_level), 32'd2);
    check("rehit.first", gn_data, corrected(0, 30'h55));
    step(4'b0000, 30'd0, 1'b1, "rehit_drain");
    check("rehit.second", gn_data, corrected(0, 30'h56));
    step(4'b0000, 30'd0, 1'b1, "rehit_drain");

    // Reset mid-operation with three entries queued and lanes 0 and 2 pending
    step(4'b0111, 30'h77, 1'b0, "rst_fill");
    for (int k = 0; k < 3; k++) step(4'b0000, 30'd0, 1'b0, "rst_fill");
    step(4'b0101, 30'h88, 1'b0, "rst_pend");
    check("rst.pre_level", 32'(fifo_level), 32'd3);
    is_golden = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.valid", 32'(gn_valid), 32'd0);
    check("rst.level", 32'(fifo_level), 32'd0);
`ifdef GN_DROP_COUNT_EN
    check("rst.drops", 32'(drop_count), 32'd0);
`endif
    model_reset();
    @(posedge hash_clk);
    @(negedge hash_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(4'b0000, 30'd0, 1'b1, "rst_after");
    check("rst.no_stale", 32'(gn_valid), 32'd0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  g;
      logic [29:0] n;
      bit          r;
      g = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      n = 30'($urandom);
      r = ($urandom_range(0, 2) == 0);
      step(g, n, r, "rand");
    end
    for (int k = 0; k < 12; k++) step(4'b0000, 30'd0, 1'b1, "rand_drain");
    check("rand.empty", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
